// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity checker.
// FSM state encoding, statistics counter width and bit-counter sizing.
package serial_parity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam int ERR_COUNT_W = 8;

   // Wide enough to hold the value n itself, so a full frame count never wraps.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/xor_nor_acc.sv
// 1-bit registered parity accumulator: q <= q ^ d when en, cleared by clr.
// The XOR feeding the flop is built only from NOR gates.
module xor_nor_acc (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic d,
   output logic q
);

   logic n1, n2, n3, n4, x;

   // Five-NOR XOR: n4 is XNOR(q,d), n5 inverts it.
   assign n1 = ~(q | d);
   assign n2 = ~(q | n1);
   assign n3 = ~(d | n1);
   assign n4 = ~(n2 | n3);
   assign x  = ~(n4 | n4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= 1'b0;
      else if (clr) q <= 1'b0;
      else if (en)  q <= x;
   end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial XOR-parity receiver: start bit, DATA_W data bits LSB first, parity bit.
// Define PARITY_CHECKER_STATS_EN to build the saturating parity-error counter.
module serial_parity_checker
   import serial_parity_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   din,
   input  logic                   din_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_par_err,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   overrun,
   output logic [ERR_COUNT_W-1:0] err_count
);

   localparam int CNT_W = cnt_width(DATA_W);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              acc_q, acc_clr, acc_en;
   logic              start_bit, par_done, par_err_nxt;

   assign start_bit   = din_valid & din;
   assign par_done    = (state == PARITY) & din_valid;
   assign par_err_nxt = acc_q ^ din ^ PARITY_ODD;

   xor_nor_acc u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr),
      .en    (acc_en),
      .d     (din),
      .q     (acc_q)
   );

   always_comb begin
      state_nxt = state;
      acc_clr   = 1'b0;
      acc_en    = 1'b0;
      case (state)
         IDLE: begin
            if (start_bit) begin
               state_nxt = DATA;
               acc_clr   = 1'b1;
            end
         end
         DATA: begin
            if (din_valid) begin
               acc_en = 1'b1;
               if (bit_cnt == CNT_W'(DATA_W - 1)) state_nxt = PARITY;
            end
         end
         PARITY: begin
            if (din_valid) state_nxt = HOLD;
         end
         HOLD: begin
            // A start bit coincident with the transfer skips IDLE for full rate.
            if (out_ready) begin
               if (start_bit) begin
                  state_nxt = DATA;
                  acc_clr   = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         state <= state_nxt;
         if (acc_clr) begin
            bit_cnt <= '0;
            shreg   <= '0;
         end else if (acc_en) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            for (int i = 0; i < DATA_W; i++)
               if (bit_cnt == CNT_W'(i)) shreg[i] <= din;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data    <= '0;
         out_par_err <= 1'b0;
         out_valid   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (par_done) begin
            out_data    <= shreg;
            out_par_err <= par_err_nxt;
            out_valid   <= 1'b1;
         end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
         end
         // Frame arriving while the held word is unaccepted is dropped.
         if (state == HOLD && !out_ready && start_bit) overrun <= 1'b1;
      end
   end

`ifdef PARITY_CHECKER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count <= '0;
      else if (par_done && par_err_nxt && err_count != {ERR_COUNT_W{1'b1}})
         err_count <= err_count + ERR_COUNT_W'(1);
   end
`else
   assign err_count = '0;
`endif

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Receiving end of the team's XOR-parity link: accepts a serial frame of one start bit, DATA_W data bits (LSB first) and one parity bit. It reassembles the data word, recomputes parity with a running XOR, and presents the word plus a parity-error flag on a valid/ready output port. It sits between the serial line sampler and the word-level consumer, mirroring the parity generator on the transmit side.

## Interface
- DATA_W, default 8: data bits per frame (2..32).
- PARITY_ODD, default 0: 0 = even parity expected, 1 = odd parity expected.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial bit.
- din_valid  input  1  din carries a bit this cycle. Cycles with din_valid=0 are ignored (stall).
- out_data  output  DATA_W  reassembled word.
- out_par_err  output  1  received parity mismatched expected parity. Qualified by out_valid.
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts the word.
- overrun  output  1  sticky. A start bit arrived while a word was still unaccepted.
- err_count  output  8  saturating count of parity errors (see Configuration).

## Operation
- FSM states: IDLE, DATA, PARITY, HOLD.
- IDLE: din_valid && din==1 is the start bit. Clear shift register, bit counter and parity accumulator, then go to DATA. din_valid && din==0 is line idle; stay in IDLE.
- DATA: on each din_valid, shift din into bit [count] (LSB first) and update acc ^= din. After DATA_W accepted bits, go to PARITY.
- PARITY: on din_valid, compute err = acc ^ din ^ PARITY_ODD. Latch out_data and out_par_err, set out_valid, and go to HOLD.
- HOLD: out_valid=1 with out_data/out_par_err stable.
  - out_ready=1: transfer completes; clear out_valid.
  - Same cycle as the transfer, din_valid && din==1: start bit accepted, go directly to DATA (no idle cycle needed).
  - Otherwise after the transfer: go to IDLE.
  - out_ready=0 and a start bit arrives: set overrun, drop that frame, stay in HOLD. Subsequent bits of the dropped frame are treated as idle/start per HOLD rules.
- Data is delivered even when out_par_err=1.
- Bit counter width is clog2(DATA_W+1). It never wraps within a frame.

## Timing
- Reset (async assert, sync-free deassert):
  - State goes to IDLE.
  - out_data=0, out_par_err=0, out_valid=0, overrun=0, err_count=0.
- Reset mid-frame or mid-HOLD: the partial or pending word is discarded with no output.
- Latency: out_valid rises on the clock edge that samples the parity bit. It is visible the cycle after the parity bit is presented.
- Minimum frame: DATA_W+2 valid cycles. Back-to-back frames sustain full rate when out_ready is held at 1.
- Outputs are registered; no combinational path from din to the outputs.

## Configuration
- PARITY_CHECKER_STATS_EN defined:
  - err_count increments by 1 on each completed frame with out_par_err=1, at the same edge out_valid rises.
  - It saturates at 255 and is cleared only by reset.
- Not defined: err_count is tied to 0 and no counter logic is synthesized.

## Structure
- Package serial_parity_pkg holds:
  - the FSM state enum (IDLE, DATA, PARITY, HOLD);
  - the ERR_COUNT_W=8 constant;
  - a clog2-based counter-width function.
- One sub-module, xor_nor_acc: 1-bit registered parity accumulator.
  - Next-state XOR is built from five NOR gates.
  - Ports: clk, rst_n, clr, en, d, q.

## Test plan
- Even parity, DATA_W=8: start 1, bits 1,0,1,0,0,1,0,1, parity 0, out_ready=1 -> out_data=0xA5, out_par_err=0, out_valid for 1 cycle.
- Same frame with parity bit 1 -> out_data=0xA5, out_par_err=1. With STATS_EN, err_count=1.
- Frame 0x01 with parity 1 and din_valid=0 gaps of 3 cycles between bits -> out_data=0x01, out_par_err=0, out_valid one cycle after the parity bit.
- out_ready=0 after a frame, then a new start bit -> overrun=1, first word held unchanged. Raising out_ready releases it; overrun stays 1.
- Assert rst_n=0 after 4 data bits -> all outputs 0 immediately, state IDLE. A full frame 0x3C afterwards is received correctly.
- 300 bad-parity frames with STATS_EN -> err_count=255. Without the macro, err_count=0 throughout.
